// File: rtl/eth_tx_gen_pkg.sv
// rtl/eth_tx_gen_pkg.sv - shared constants, state and config types for the TX packet generator
package eth_tx_gen_pkg;
  localparam int DATA_W         = 512;
  localparam int BYTES_PER_BEAT = 64;
  localparam int EMPTY_W        = 6;
  localparam int HDR_BYTES      = 14;
  localparam int LEN_W          = 14;
  localparam int BEAT_W         = 8;

  typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} gen_state_t;

  typedef struct packed {
    logic [LEN_W-1:0] len;
    logic [31:0]      count;
    logic [7:0]       ipg;
    logic [47:0]      dst;
    logic [47:0]      src;
    logic [15:0]      ethertype;
  } gen_cfg_t;

  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len,
                                                 input int min_len, input int max_len);
    if (int'(len) < min_len) return LEN_W'(min_len);
    if (int'(len) > max_len) return LEN_W'(max_len);
    return len;
  endfunction
endpackage

// File: rtl/eth_tx_beat_fmt.sv
// rtl/eth_tx_beat_fmt.sv - combinational builder of one 64-byte frame beat
module eth_tx_beat_fmt
  import eth_tx_gen_pkg::*;
(
  input  logic [BEAT_W-1:0]  beat_idx,
  input  logic [7:0]         frame_idx,
  input  gen_cfg_t           cfg,
  output logic [DATA_W-1:0]  data,
  output logic               eop,
  output logic [EMPTY_W-1:0] empty
);
  logic [HDR_BYTES*8-1:0] hdr;
  logic [7:0]             hdr_b [16];
  logic [15:0]            base;
  logic [15:0]            len16;
  logic [LEN_W-1:0]       neg_len;

  assign hdr     = {cfg.dst, cfg.src, cfg.ethertype};
  assign base    = {2'b00, beat_idx, 6'b000000};
  assign len16   = {2'b00, cfg.len};
  assign neg_len = -cfg.len;
  assign eop     = (base + 16'd64) >= len16;
  assign empty   = eop ? neg_len[EMPTY_W-1:0] : '0;

  // Two spare zero entries let the lookup use a plain 4-bit index.
  for (genvar h = 0; h < 16; h++) begin : g_hdr
    if (h < HDR_BYTES) begin : g_real
      assign hdr_b[h] = hdr[HDR_BYTES*8-1-8*h -: 8];
    end else begin : g_pad
      assign hdr_b[h] = 8'h00;
    end
  end

  for (genvar g = 0; g < BYTES_PER_BEAT; g++) begin : g_byte
    logic [15:0] k;
    logic [15:0] pay;
    assign k   = base + 16'(g);
    assign pay = k - 16'(HDR_BYTES) + {8'h00, frame_idx};
    assign data[DATA_W-1-8*g -: 8] = (k < 16'(HDR_BYTES)) ? hdr_b[k[3:0]] :
                                     (k < len16)          ? pay[7:0]      : 8'h00;
  end
endmodule

// File: rtl/eth_tx_pkt_gen.sv
// rtl/eth_tx_pkt_gen.sv - Avalon-ST Ethernet frame source for the 100G MAC TX sink
module eth_tx_pkt_gen
  import eth_tx_gen_pkg::*;
#(
  parameter int MAX_LEN = 9600,
  parameter int MIN_LEN = 60
) (
  input  logic                i_clk_tx,
  input  logic                i_tx_rst_n,
  input  logic                i_start,
  input  logic                i_stop,
  input  logic [13:0]         i_pkt_len,
  input  logic [31:0]         i_pkt_count,
  input  logic [7:0]          i_ipg_cycles,
  input  logic [47:0]         i_dst_mac,
  input  logic [47:0]         i_src_mac,
  input  logic [15:0]         i_ethertype,
  input  logic                i_inject_err,
  input  logic                i_tx_ready,
  output logic                o_tx_valid,
  output logic [511:0]        o_tx_data,
  output logic                o_tx_sop,
  output logic                o_tx_eop,
  output logic [5:0]          o_tx_empty,
  output logic                o_tx_error,
  output logic                o_tx_skip_crc,
  output logic                o_busy,
  output logic                o_done,
  output logic [31:0]         o_pkt_sent
);
  gen_state_t          state;
  gen_cfg_t            cfg, in_cfg, fmt_cfg;
  logic [BEAT_W-1:0]   beat_idx, fmt_beat;
  logic [7:0]          frame_idx, fmt_frame, gap_cnt;
  logic                stop_pend, err_flag;
  logic [DATA_W-1:0]   fmt_data;
  logic                fmt_eop;
  logic [EMPTY_W-1:0]  fmt_empty;
  logic                acc, sop_acc, eop_acc, last_frame, load, err_src;

  assign o_tx_skip_crc = 1'b0;
  assign acc     = o_tx_valid & i_tx_ready;
  assign sop_acc = acc & o_tx_sop;
  assign eop_acc = acc & o_tx_eop;
  assign last_frame = ((cfg.count != 32'd0) && (o_pkt_sent + 32'd1 == cfg.count)) ||
                      stop_pend || i_stop;
  // The error request is taken live while the SOP beat is loaded or accepted, then held.
  assign err_src = ((fmt_beat == '0) || sop_acc) ? i_inject_err : err_flag;

  always_comb begin
    in_cfg           = '0;
    in_cfg.len       = clamp_len(i_pkt_len, MIN_LEN, MAX_LEN);
    in_cfg.count     = i_pkt_count;
    in_cfg.ipg       = i_ipg_cycles;
    in_cfg.dst       = i_dst_mac;
    in_cfg.src       = i_src_mac;
    in_cfg.ethertype = i_ethertype;
  end

  // Select the beat that the output register will take next.
  always_comb begin
    fmt_cfg   = cfg;
    fmt_beat  = '0;
    fmt_frame = frame_idx;
    case (state)
      IDLE: begin
        fmt_cfg   = in_cfg;
        fmt_frame = '0;
      end
      SEND: begin
        if (o_tx_eop) fmt_frame = frame_idx + 8'd1;
        else          fmt_beat  = beat_idx + 8'd1;
      end
      default: ;
    endcase
  end

  always_comb begin
    load = 1'b0;
    case (state)
      IDLE:    load = i_start & ~i_stop;
      SEND:    load = acc & ~(o_tx_eop & (last_frame | (cfg.ipg != 8'd0)));
      GAP:     load = ~stop_pend & ~i_stop & (gap_cnt == 8'd1);
      default: load = 1'b0;
    endcase
  end

  eth_tx_beat_fmt u_fmt (
    .beat_idx  (fmt_beat),
    .frame_idx (fmt_frame),
    .cfg       (fmt_cfg),
    .data      (fmt_data),
    .eop       (fmt_eop),
    .empty     (fmt_empty)
  );

  always_ff @(posedge i_clk_tx or negedge i_tx_rst_n) begin
    if (!i_tx_rst_n) begin
      state      <= IDLE;
      cfg        <= '0;
      beat_idx   <= '0;
      frame_idx  <= '0;
      gap_cnt    <= '0;
      stop_pend  <= 1'b0;
      err_flag   <= 1'b0;
      o_tx_valid <= 1'b0;
      o_tx_data  <= '0;
      o_tx_sop   <= 1'b0;
      o_tx_eop   <= 1'b0;
      o_tx_empty <= '0;
      o_tx_error <= 1'b0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_pkt_sent <= '0;
    end else begin
      o_done <= 1'b0;
      if (load) begin
        o_tx_valid <= 1'b1;
        o_tx_data  <= fmt_data;
        o_tx_sop   <= (fmt_beat == '0);
        o_tx_eop   <= fmt_eop;
        o_tx_empty <= fmt_empty;
        o_tx_error <= fmt_eop & err_src;
        beat_idx   <= fmt_beat;
      end else if (eop_acc) begin
        o_tx_valid <= 1'b0;
        o_tx_data  <= '0;
        o_tx_sop   <= 1'b0;
        o_tx_eop   <= 1'b0;
        o_tx_empty <= '0;
        o_tx_error <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (i_start && !i_stop) begin
            state      <= SEND;
            cfg        <= in_cfg;
            o_busy     <= 1'b1;
            o_pkt_sent <= '0;
            frame_idx  <= '0;
            stop_pend  <= 1'b0;
          end
        end
        SEND: begin
          if (i_stop)  stop_pend <= 1'b1;
          if (sop_acc) err_flag  <= i_inject_err;
          if (eop_acc) begin
            o_pkt_sent <= o_pkt_sent + 32'd1;
            frame_idx  <= frame_idx + 8'd1;
            if (last_frame) begin
              state  <= DONE;
              o_busy <= 1'b0;
              o_done <= 1'b1;
            end else if (cfg.ipg != 8'd0) begin
              state   <= GAP;
              gap_cnt <= cfg.ipg;
            end
          end
        end
        GAP: begin
          if (stop_pend || i_stop) begin
            state  <= DONE;
            o_busy <= 1'b0;
            o_done <= 1'b1;
          end else if (gap_cnt == 8'd1) begin
            state <= SEND;
          end else begin
            gap_cnt <= gap_cnt - 8'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_eth_tx_pkt_gen.sv
// tb/tb_eth_tx_pkt_gen.sv - self-checking bench for eth_tx_pkt_gen with a frame-level reference model
module tb_eth_tx_pkt_gen;
  logic         clk;
  logic         rst_n;
  logic         i_start, i_stop, i_inject_err, i_tx_ready;
  logic [13:0]  i_pkt_len;
  logic [31:0]  i_pkt_count;
  logic [7:0]   i_ipg_cycles;
  logic [47:0]  i_dst_mac, i_src_mac;
  logic [15:0]  i_ethertype;
  logic         o_tx_valid, o_tx_sop, o_tx_eop, o_tx_error, o_tx_skip_crc, o_busy, o_done;
  logic [511:0] o_tx_data;
  logic [5:0]   o_tx_empty;
  logic [31:0]  o_pkt_sent;

  int errors = 0;
  int checks = 0;

  // reference model state
  int          m_len, m_ipg, m_limit;
  logic [7:0]  m_hdr [14];
  int          m_frame, m_beat, m_gap, m_last_beats, err_beats;
  logic [31:0] m_sent;
  logic        m_in_frame, m_inj, held, start_req, chk_en, rdy_toggle;
  logic [511:0] h_data, cap_first, cap_f1b0;
  logic [8:0]  h_ctl;
  logic [5:0]  m_last_empty;

  eth_tx_pkt_gen dut (
    .i_clk_tx(clk), .i_tx_rst_n(rst_n), .i_start(i_start), .i_stop(i_stop),
    .i_pkt_len(i_pkt_len), .i_pkt_count(i_pkt_count), .i_ipg_cycles(i_ipg_cycles),
    .i_dst_mac(i_dst_mac), .i_src_mac(i_src_mac), .i_ethertype(i_ethertype),
    .i_inject_err(i_inject_err), .i_tx_ready(i_tx_ready), .o_tx_valid(o_tx_valid),
    .o_tx_data(o_tx_data), .o_tx_sop(o_tx_sop), .o_tx_eop(o_tx_eop), .o_tx_empty(o_tx_empty),
    .o_tx_error(o_tx_error), .o_tx_skip_crc(o_tx_skip_crc), .o_busy(o_busy), .o_done(o_done),
    .o_pkt_sent(o_pkt_sent)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    i_tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_toggle) i_tx_ready = ~i_tx_ready;
      else            i_tx_ready = 1'b1;
    end
  end

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [511:0] exp_beat(input int n, input int b);
    logic [511:0] d;
    logic [7:0]   v;
    int           k;
    d = '0;
    for (int j = 0; j < 64; j++) begin
      k = b * 64 + j;
      if (k < 14)         v = m_hdr[k];
      else if (k < m_len) v = 8'((k - 14 + n) % 256);
      else                v = 8'h00;
      d = {d[503:0], v};
    end
    return d;
  endfunction

  always @(negedge clk) begin
    logic       exp_eop;
    logic [8:0] ctl_e;
    if (!rst_n) begin
      m_sent = 0; m_frame = 0; m_beat = 0; m_in_frame = 0; held = 0;
    end else if (chk_en) begin
      chk("pkt_sent", o_pkt_sent, m_sent);
      if (held) begin
        chk("hold_valid", o_tx_valid, 1'b1);
        chk("hold_data", o_tx_data, h_data);
        chk("hold_ctl", {o_tx_sop, o_tx_eop, o_tx_empty, o_tx_error}, h_ctl);
      end else if (m_in_frame) begin
        chk("valid_in_frame", o_tx_valid, 1'b1);
      end
      held = 0;
      if (o_tx_valid) begin
        if (m_beat == 0) begin
          chk("frame_limit", m_frame < m_limit, 1'b1);
          if (m_frame > 0) chk("ipg_gap", m_gap, m_ipg);
        end
        exp_eop = ((m_beat + 1) * 64) >= m_len;
        ctl_e = {m_beat == 0, exp_eop, exp_eop ? 6'((64 - m_len % 64) % 64) : 6'd0,
                 exp_eop && ((m_beat == 0) ? i_inject_err : m_inj)};
        chk("beat_data", o_tx_data, exp_beat(m_frame, m_beat));
        chk("beat_ctl", {o_tx_sop, o_tx_eop, o_tx_empty, o_tx_error}, ctl_e);
        if (i_tx_ready) begin
          if (m_beat == 0) m_inj = i_inject_err;
          if (o_tx_error) err_beats++;
          if (m_frame == 0 && m_beat == 0) cap_first = o_tx_data;
          if (m_frame == 1 && m_beat == 0) cap_f1b0 = o_tx_data;
          if (exp_eop) begin
            m_sent++; m_frame++; m_last_beats = m_beat + 1; m_last_empty = o_tx_empty;
            m_beat = 0; m_in_frame = 0; m_gap = 0;
          end else begin
            m_beat++; m_in_frame = 1;
          end
        end else begin
          held = 1; h_data = o_tx_data; h_ctl = {o_tx_sop, o_tx_eop, o_tx_empty, o_tx_error};
        end
      end else if (!m_in_frame) begin
        m_gap++;
      end
    end
    if (start_req) begin
      m_sent = 0; m_frame = 0; m_beat = 0; m_in_frame = 0; m_gap = 0; held = 0;
      m_inj = 0; err_beats = 0; m_last_beats = 0; m_last_empty = 0;
      start_req = 0;
    end
  end

  task automatic run(input int len, input int count, input int ipg);
    @(posedge clk);
    #1;
    i_pkt_len = 14'(len); i_pkt_count = count; i_ipg_cycles = 8'(ipg);
    m_len   = (len < 60) ? 60 : (len > 9600) ? 9600 : len;
    m_ipg   = ipg;
    m_limit = (count == 0) ? 32'h7fffffff : count;
    for (int k = 0; k < 6; k++) begin
      m_hdr[k]     = 8'(i_dst_mac >> (40 - 8 * k));
      m_hdr[6 + k] = 8'(i_src_mac >> (40 - 8 * k));
    end
    m_hdr[12] = i_ethertype[15:8];
    m_hdr[13] = i_ethertype[7:0];
    chk_en = 1; start_req = 1; i_start = 1;
    @(posedge clk);
    #1;
    i_start = 0;
  endtask

  task automatic wait_done(input string name, input int bound, input logic [31:0] exp_sent);
    bit seen;
    seen = 0;
    for (int i = 0; i < bound && !seen; i++) begin
      @(negedge clk);
      if (o_done) seen = 1;
    end
    chk({name, "_done_seen"}, seen, 1'b1);
    if (seen) begin
      chk({name, "_busy_low"}, o_busy, 1'b0);
      chk({name, "_sent"}, o_pkt_sent, exp_sent);
    end
  endtask

  initial begin
    int nsop;
    bit seen;
    rst_n = 0; i_start = 0; i_stop = 0; i_inject_err = 0; rdy_toggle = 0;
    chk_en = 0; start_req = 0; m_limit = 0; m_len = 60; m_ipg = 0;
    i_pkt_len = 0; i_pkt_count = 0; i_ipg_cycles = 0;
    i_dst_mac = 48'h0A1B2C3D4E5F; i_src_mac = 48'h001122334455; i_ethertype = 16'h88B5;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {o_tx_valid, o_tx_sop, o_tx_eop, o_tx_empty, o_tx_error, o_busy,
                          o_done, o_pkt_sent, o_tx_data, o_tx_skip_crc}, '0);
    rst_n = 1;

    // single-beat minimum frame
    run(60, 1, 0);
    wait_done("t1", 50, 32'd1);
    chk("t1_first_byte", cap_first[511:504], 8'h0A);
    chk("t1_tail_zero", cap_first[31:0], 32'h0);
    chk("t1_beats", m_last_beats, 1);
    chk("t1_empty", m_last_empty, 6'd4);

    // two-beat frames with a 2-cycle gap
    run(65, 3, 2);
    wait_done("t2", 100, 32'd3);
    chk("t2_f1_byte14", cap_f1b0[399:392], 8'h01);
    chk("t2_beats", m_last_beats, 2);
    chk("t2_empty", m_last_empty, 6'd63);

    // backpressure on alternate cycles
    rdy_toggle = 1;
    run(1518, 2, 1);
    wait_done("t3", 300, 32'd2);
    chk("t3_beats", m_last_beats, 24);
    chk("t3_empty", m_last_empty, 6'd18);
    rdy_toggle = 0;

    // continuous run stopped inside the first jumbo frame
    run(9600, 0, 0);
    repeat (5) @(posedge clk);
    #1;
    i_stop = 1; m_limit = m_frame + 1;
    @(posedge clk);
    #1;
    i_stop = 0;
    wait_done("t4", 400, 32'd1);
    repeat (10) @(posedge clk);
    chk("t4_beats", m_last_beats, 150);
    chk("t4_empty", m_last_empty, 6'd0);
    chk("t4_frames", m_frame, 1);

    // error injected on the third frame of four
    run(200, 4, 3);
    nsop = 0; seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(posedge clk);
      #1;
      i_inject_err = o_tx_valid && o_tx_sop && nsop == 2;
      if (o_tx_valid && o_tx_sop) nsop++;
      if (o_done) seen = 1;
    end
    i_inject_err = 0;
    chk("t5_done_seen", seen, 1'b1);
    chk("t5_sent", o_pkt_sent, 32'd4);
    chk("t5_err_beats", err_beats, 1);

    // length clamping at both ends
    run(10, 1, 0);
    wait_done("t7a", 50, 32'd1);
    chk("t7a_beats", m_last_beats, 1);
    chk("t7a_empty", m_last_empty, 6'd4);
    run(12000, 1, 0);
    wait_done("t7b", 300, 32'd1);
    chk("t7b_beats", m_last_beats, 150);
    chk("t7b_empty", m_last_empty, 6'd0);

    // start and stop together: run never begins
    @(posedge clk);
    #1;
    i_start = 1; i_stop = 1;
    @(posedge clk);
    #1;
    i_start = 0; i_stop = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("t8_idle", {o_busy, o_tx_valid, o_done}, 3'b000);

    // asynchronous reset mid-frame, then a fresh run
    run(1000, 1, 0);
    repeat (4) @(posedge clk);
    #1;
    chk_en = 0; rst_n = 0;
    #1;
    chk("t6_reset_async", {o_tx_valid, o_tx_sop, o_tx_eop, o_tx_empty, o_tx_error, o_busy,
                           o_done, o_pkt_sent, o_tx_data}, '0);
    @(posedge clk);
    #1;
    rst_n = 1;
    run(130, 2, 1);
    wait_done("t6", 100, 32'd2);
    chk("t6_payload0", cap_first[399:392], 8'h00);
    chk("t6_beats", m_last_beats, 3);
    chk("t6_empty", m_last_empty, 6'd62);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
